// File: rtl/osd_pkg.sv
// Shared OSD glyph-ROM widths and arbiter FSM states; used by the arbiter and the downstream read mux.
// Pure declarations: no latency, no flow control.
package osd_pkg;

  localparam int OSD_ADDR_W = 13;
  localparam int OSD_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } osd_state_e;

  // Port-index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/osd_rr_pick.sv
// Combinational round-robin pick: first requesting port after last_i, wrapping around.
// Zero latency; no flow control of its own.
module osd_rr_pick
  import osd_pkg::*;
#(
  parameter int PORT_NUM = 5,
  parameter int IDX_W    = idx_w(PORT_NUM)
) (
  input  logic [PORT_NUM-1:0] req_i,
  input  logic [IDX_W-1:0]    last_i,
  output logic [PORT_NUM-1:0] gnt_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic                any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 1; i <= PORT_NUM; i++) begin
      cand = IDX_W'((int'(last_i) + i) % PORT_NUM);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/osd_rom_arbiter.sv
// Round-robin arbiter of PORT_NUM requesters onto one glyph ROM; one read in flight, response READ_LAT+2 cycles after the request is seen.
// Requests are level-held until o_rsp_vld; a new grant can be issued in the response cycle.
module osd_rom_arbiter
  import osd_pkg::*;
#(
  parameter int PORT_NUM = 5,
  parameter int READ_LAT = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [PORT_NUM-1:0]            i_req,
  input  logic [PORT_NUM*OSD_ADDR_W-1:0] i_addr,
  output logic [PORT_NUM-1:0]            o_rsp_vld,
  output logic [PORT_NUM*OSD_DATA_W-1:0] o_rsp_data,
  output logic                           o_busy,
  output logic [PORT_NUM-1:0]            o_addr_req,
  output logic [PORT_NUM*OSD_ADDR_W-1:0] o_rd_addr,
  input  logic [PORT_NUM*OSD_DATA_W-1:0] i_rd_data
);

  localparam int IDX_W = idx_w(PORT_NUM);
  localparam int CNT_W = $clog2(READ_LAT + 1);

  osd_state_e                      state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]                last_q, last_d;
  logic [IDX_W-1:0]                win_q, win_d;
  logic [PORT_NUM-1:0]             addr_req_q, addr_req_d;
  logic [PORT_NUM*OSD_ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic                            busy_q, busy_d;
  logic [PORT_NUM-1:0]             rsp_vld_q, rsp_vld_d;
  logic [PORT_NUM*OSD_DATA_W-1:0]  rsp_data_q, rsp_data_d;

  logic [PORT_NUM-1:0] elig, pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                lat_done;

  // The port being answered this cycle must not be picked again off its still-held request.
  assign elig     = i_req & ~rsp_vld_q;
  assign lat_done = (cnt_q == CNT_W'(READ_LAT));

  osd_rr_pick #(
    .PORT_NUM (PORT_NUM),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req_i  (elig),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_q     <= IDX_W'(PORT_NUM - 1);
      win_q      <= '0;
      addr_req_q <= '0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      win_q      <= win_d;
      addr_req_q <= addr_req_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // RESP doubles as an arbitration slot so back-to-back reads run every READ_LAT+2 cycles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pick_any) state_d = ST_WAIT;
      ST_WAIT: if (lat_done) state_d = ST_RESP;
      ST_RESP: state_d = pick_any ? ST_WAIT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    last_d     = last_q;
    win_d      = win_q;
    addr_req_d = addr_req_q;
    rd_addr_d  = rd_addr_q;
    busy_d     = busy_q;
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    if (state_q == ST_WAIT) begin
      if (lat_done) begin
        addr_req_d       = '0;
        rd_addr_d        = '0;
        busy_d           = 1'b0;
        rsp_vld_d[win_q] = 1'b1;
        rsp_data_d[int'(win_q)*OSD_DATA_W +: OSD_DATA_W] =
          i_rd_data[int'(win_q)*OSD_DATA_W +: OSD_DATA_W];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pick_any) begin
      addr_req_d = pick_gnt;
      rd_addr_d  = '0;
      rd_addr_d[int'(pick_idx)*OSD_ADDR_W +: OSD_ADDR_W] =
        i_addr[int'(pick_idx)*OSD_ADDR_W +: OSD_ADDR_W];
      busy_d     = 1'b1;
      cnt_d      = '0;
      last_d     = pick_idx;
      win_d      = pick_idx;
    end else begin
      addr_req_d = '0;
      rd_addr_d  = '0;
      busy_d     = 1'b0;
    end
  end

  assign o_addr_req = addr_req_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_busy     = busy_q;
  assign o_rsp_vld  = rsp_vld_q;
  assign o_rsp_data = rsp_data_q;

endmodule
